// File: rtl/runtime_feature_ctrl_if.sv
// Feature-change request/response handshake between a requester and runtime_feature_ctrl.
interface runtime_feature_ctrl_if #(
   parameter int unsigned NrHarts = 1
);
   localparam int unsigned HartW = (NrHarts > 1) ? $clog2(NrHarts) : 1;

   logic             req_valid_i;
   logic             req_ready_o;
   logic [HartW-1:0] req_hart_i;
   logic [11:0]      req_feat_i;
   logic             rsp_valid_o;
   logic             rsp_err_o;
   logic [11:0]      rsp_feat_o;

   modport master (
      output req_valid_i, req_hart_i, req_feat_i,
      input  req_ready_o, rsp_valid_o, rsp_err_o, rsp_feat_o
   );

   modport slave (
      input  req_valid_i, req_hart_i, req_feat_i,
      output req_ready_o, rsp_valid_o, rsp_err_o, rsp_feat_o
   );
endinterface

// File: rtl/runtime_feature_ctrl.sv
// Per-hart runtime ISA feature register with legalization and a drain/apply handshake.
// One global FSM serves all harts; only one feature-change request is in flight.
module runtime_feature_ctrl #(
   parameter int unsigned NrHarts      = 1,
   parameter logic [11:0] HwCaps       = 12'hFFF,
   parameter logic [11:0] RstFeat      = 12'hFFF,
   parameter int unsigned DrainTimeout = 64,
   parameter bit          CvxifEn      = 1'b0
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   runtime_feature_ctrl_if.slave   req_if,
   output logic [NrHarts-1:0]      flush_req_o,
   input  logic [NrHarts-1:0]      idle_i,
   output logic [NrHarts*12-1:0]   feat_o,
   output logic [NrHarts*7-1:0]    flen_o,
   output logic [NrHarts*3-1:0]    nr_wb_ports_o
);
   localparam int unsigned HartW = (NrHarts > 1) ? $clog2(NrHarts) : 1;
   localparam int unsigned CntW  = (DrainTimeout > 2) ? $clog2(DrainTimeout) : 1;

   function automatic logic [6:0] flen_of(input logic [11:0] f);
      if (f[1])             return 7'd64;
      else if (f[0])        return 7'd32;
      else if (f[2] | f[3]) return 7'd16;
      else if (f[4])        return 7'd8;
      else                  return 7'd1;
   endfunction

   // XFVec only makes sense when FLen is wider than the narrowest FP format enabled.
   function automatic logic [11:0] legalize(input logic [11:0] r);
      logic [11:0] l;
      logic [6:0]  min_w;
      l = r & HwCaps;
      if (!l[0])  l[1]  = 1'b0;
      if (!l[11]) l[10] = 1'b0;
      min_w = l[4] ? 7'd8 : (l[2] | l[3]) ? 7'd16 : l[0] ? 7'd32 : 7'd127;
      if (!(flen_of(l) > min_w)) l[5] = 1'b0;
      return l;
   endfunction

   localparam logic [11:0] RstLegal = legalize(RstFeat);

   typedef enum logic [1:0] {IDLE, DRAIN, APPLY, RESP} state_e;

   state_e                    state_q;
   logic [HartW-1:0]          hart_q;
   logic [11:0]               nfeat_q;
   logic [CntW-1:0]           cnt_q;
   logic [NrHarts-1:0][11:0]  feat_q;
   logic [NrHarts-1:0]        flush_q;
   logic                      rsp_valid_q, rsp_err_q;
   logic [11:0]               rsp_feat_q;

   logic [11:0]               req_cur, req_legal, act_feat;
   logic                      act_idle, req_hart_ok;
   logic [NrHarts-1:0]        req_onehot;

   assign req_legal   = legalize(req_if.req_feat_i);
   assign req_hart_ok = 32'(req_if.req_hart_i) < NrHarts;

   always_comb begin
      req_cur    = '0;
      req_onehot = '0;
      act_feat   = '0;
      act_idle   = 1'b0;
      for (int unsigned h = 0; h < NrHarts; h++) begin
         if (32'(req_if.req_hart_i) == h) begin
            req_cur       = feat_q[h];
            req_onehot[h] = 1'b1;
         end
         if (32'(hart_q) == h) begin
            act_feat = feat_q[h];
            act_idle = idle_i[h];
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= IDLE;
         hart_q      <= '0;
         nfeat_q     <= '0;
         cnt_q       <= '0;
         feat_q      <= {NrHarts{RstLegal}};
         flush_q     <= '0;
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
         rsp_feat_q  <= '0;
      end else begin
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
         rsp_feat_q  <= '0;
         case (state_q)
            IDLE: if (req_if.req_valid_i) begin
               hart_q  <= req_if.req_hart_i;
               nfeat_q <= req_legal;
               if (!req_hart_ok) begin
                  state_q     <= RESP;
                  rsp_valid_q <= 1'b1;
                  rsp_err_q   <= 1'b1;
               end else if (req_legal == req_cur) begin
                  state_q     <= RESP;
                  rsp_valid_q <= 1'b1;
                  rsp_feat_q  <= req_cur;
               end else begin
                  state_q <= DRAIN;
                  cnt_q   <= '0;
                  flush_q <= req_onehot;
               end
            end
            DRAIN: begin
               if (act_idle) begin
                  state_q <= APPLY;
               end else if (cnt_q == CntW'(DrainTimeout - 1)) begin
                  state_q     <= RESP;
                  flush_q     <= '0;
                  rsp_valid_q <= 1'b1;
                  rsp_err_q   <= 1'b1;
                  rsp_feat_q  <= act_feat;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            APPLY: begin
               for (int unsigned h = 0; h < NrHarts; h++)
                  if (32'(hart_q) == h) feat_q[h] <= nfeat_q;
               state_q     <= RESP;
               flush_q     <= '0;
               rsp_valid_q <= 1'b1;
               rsp_feat_q  <= nfeat_q;
            end
            RESP:    state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   // Reset masks the registered outputs immediately so an aborted request leaves no trace.
   assign req_if.req_ready_o = (state_q == IDLE) & ~rst_i;
   assign req_if.rsp_valid_o = rsp_valid_q & ~rst_i;
   assign req_if.rsp_err_o   = rsp_err_q & ~rst_i;
   assign req_if.rsp_feat_o  = rst_i ? 12'h000 : rsp_feat_q;
   assign flush_req_o        = rst_i ? '0 : flush_q;

   for (genvar h = 0; h < NrHarts; h++) begin : g_hart
      assign feat_o[h*12 +: 12]       = feat_q[h];
      assign flen_o[h*7 +: 7]         = flen_of(feat_q[h]);
      assign nr_wb_ports_o[h*3 +: 3]  = (CvxifEn || feat_q[h][9]) ? 3'd5 : 3'd4;
   end
endmodule

// File: tb/tb_runtime_feature_ctrl.sv
// Randomized and directed checks of runtime_feature_ctrl against a feature-rule model.
module tb_runtime_feature_ctrl;
   localparam int          NH   = 3;
   localparam int          DT   = 8;
   localparam logic [11:0] CAPS = 12'hFFF;
   localparam logic [11:0] RSTF = 12'hFFF;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic [NH-1:0]     flush;
   logic [NH-1:0]     idle = '0;
   logic [NH*12-1:0]  feat;
   logic [NH*7-1:0]   flen;
   logic [NH*3-1:0]   wb;
   int                vec = 0;
   int                errs = 0;
   logic [11:0]       mfeat [NH];

   runtime_feature_ctrl_if #(.NrHarts(NH)) bus ();

   runtime_feature_ctrl #(
      .NrHarts(NH), .HwCaps(CAPS), .RstFeat(RSTF), .DrainTimeout(DT), .CvxifEn(1'b0)
   ) dut (
      .clk_i(clk), .rst_i(rst), .req_if(bus), .flush_req_o(flush), .idle_i(idle),
      .feat_o(feat), .flen_o(flen), .nr_wb_ports_o(wb)
   );

   always #5 clk = ~clk;

   function automatic int ref_flen(input logic [11:0] f);
      if (f[1]) return 64;
      if (f[0]) return 32;
      if (f[2] || f[3]) return 16;
      if (f[4]) return 8;
      return 1;
   endfunction

   function automatic int ref_wb(input logic [11:0] f);
      return f[9] ? 5 : 4;
   endfunction

   function automatic logic [11:0] ref_legal(input logic [11:0] r);
      logic [11:0] l;
      int smallest;
      l = r & CAPS;
      if (!l[0])  l[1] = 1'b0;
      if (!l[11]) l[10] = 1'b0;
      smallest = 1000;
      if (l[0]) smallest = 32;
      if (l[2] || l[3]) smallest = 16;
      if (l[4]) smallest = 8;
      if (!(ref_flen(l) > smallest)) l[5] = 1'b0;
      return l;
   endfunction

   // Request outcome from the rules: drain ends on the first drain cycle the target looks idle.
   function automatic void expect_req(input logic [1:0] hart, input logic [11:0] rf, input int dly,
         output int lat, output logic err, output logic [11:0] fo, output int flc, output bit upd);
      logic [11:0] l;
      int first;
      upd = 0; flc = 0; err = 0; fo = '0; lat = 1;
      if (int'(hart) >= NH) begin err = 1; return; end
      l = ref_legal(rf);
      if (l == mfeat[hart]) begin fo = l; return; end
      first = (dly < 0) ? 1000 : (dly < 1 ? 1 : dly);
      if (first <= DT) begin lat = first + 2; flc = first + 1; fo = l; upd = 1; end
      else begin lat = DT + 1; flc = DT; err = 1; fo = mfeat[hart]; end
   endfunction

   // Drives one request and records what the DUT did; dly<0 means target never goes idle.
   task automatic issue(input logic [1:0] hart, input logic [11:0] rf, input int dly,
         output int lat, output logic err, output logic [11:0] fo, output int flc,
         output bit side_ok, output bit rdy_acc, output bit pulse_ok);
      logic [NH*12-1:0] f0;
      @(negedge clk);
      rdy_acc = bus.req_ready_o;
      idle = NH'($urandom);
      for (int h = 0; h < NH; h++) if (h == int'(hart)) idle[h] = (dly == 0);
      bus.req_valid_i = 1'b1;
      bus.req_hart_i  = hart;
      bus.req_feat_i  = rf;
      f0 = feat; side_ok = 1; flc = 0; lat = -1; err = 1'bx; fo = 'x; pulse_ok = 0;
      @(negedge clk);
      bus.req_valid_i = 1'b0;
      bus.req_feat_i  = 12'($urandom);
      for (int k = 1; k <= 60; k++) begin
         if (flush != 0) flc++;
         for (int h = 0; h < NH; h++)
            if (h != int'(hart) && (flush[h] || feat[h*12 +: 12] !== f0[h*12 +: 12])) side_ok = 0;
         if (bus.rsp_valid_o) begin
            lat = k; err = bus.rsp_err_o; fo = bus.rsp_feat_o;
            break;
         end
         if (k == dly)
            for (int h = 0; h < NH; h++) if (h == int'(hart)) idle[h] = 1'b1;
         @(negedge clk);
      end
      @(negedge clk);
      pulse_ok = !bus.rsp_valid_o && bus.req_ready_o && flush == 0;
   endtask

   task automatic test_reset;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         idle = NH'($urandom);
         vec++;
         if ({bus.req_ready_o, bus.rsp_valid_o, bus.rsp_err_o, bus.rsp_feat_o, flush} !== '0)
            begin errs++; $display("FAIL reset_hold: got rdy=%b vld=%b err=%b rf=%h fl=%b want all 0",
               bus.req_ready_o, bus.rsp_valid_o, bus.rsp_err_o, bus.rsp_feat_o, flush); end
      end
      rst = 1'b0;
      for (int h = 0; h < NH; h++) mfeat[h] = ref_legal(RSTF);
      #1;
      vec++;
      if (bus.req_ready_o !== 1'b1) begin errs++; $display("FAIL reset_ready: got %b want 1", bus.req_ready_o); end
      for (int h = 0; h < NH; h++) begin
         vec++;
         if ({feat[h*12 +: 12], flen[h*7 +: 7], wb[h*3 +: 3]} !== {12'hFFF, 7'd64, 3'd5})
            begin errs++; $display("FAIL reset_out[%0d]: got feat=%h flen=%0d wb=%0d want fff 64 5",
               h, feat[h*12 +: 12], flen[h*7 +: 7], wb[h*3 +: 3]); end
      end
   endtask

   task automatic test_d_without_f;
      int lat, flc; logic err; logic [11:0] fo; bit side, rdy, pulse;
      issue(2'd0, 12'h002, 0, lat, err, fo, flc, side, rdy, pulse);
      mfeat[0] = 12'h000;
      vec++; if (lat !== 3) begin errs++; $display("FAIL dnof_lat: got %0d want 3", lat); end
      vec++; if ({err, fo} !== {1'b0, 12'h000}) begin errs++; $display("FAIL dnof_rsp: got err=%b feat=%h want 0 000", err, fo); end
      vec++; if (flc !== 2) begin errs++; $display("FAIL dnof_flush: got %0d cycles want 2", flc); end
      vec++; if ({flen[6:0], wb[2:0]} !== {7'd1, 3'd4}) begin errs++; $display("FAIL dnof_derived: got flen=%0d wb=%0d want 1 4", flen[6:0], wb[2:0]); end
      vec++; if ({side, rdy, pulse} !== 3'b111) begin errs++; $display("FAIL dnof_hs: got side/rdy/pulse=%b want 111", {side, rdy, pulse}); end
   endtask

   task automatic test_no_change;
      int lat, flc; logic err; logic [11:0] fo; bit side, rdy, pulse;
      issue(2'd0, 12'h002, 0, lat, err, fo, flc, side, rdy, pulse);
      vec++; if ({lat, flc} !== {32'd1, 32'd0}) begin errs++; $display("FAIL same0: got lat=%0d flush=%0d want 1 0", lat, flc); end
      vec++; if ({err, fo} !== {1'b0, 12'h000}) begin errs++; $display("FAIL same0_rsp: got err=%b feat=%h want 0 000", err, fo); end
      issue(2'd2, 12'hFFF, 5, lat, err, fo, flc, side, rdy, pulse);
      vec++; if ({lat, flc, err, fo} !== {32'd1, 32'd0, 1'b0, 12'hFFF})
         begin errs++; $display("FAIL same2: got lat=%0d flush=%0d err=%b feat=%h want 1 0 0 fff", lat, flc, err, fo); end
   endtask

   task automatic test_timeout;
      int lat, flc; logic err; logic [11:0] fo; bit side, rdy, pulse;
      issue(2'd2, 12'h001, -1, lat, err, fo, flc, side, rdy, pulse);
      vec++; if (lat !== DT + 1) begin errs++; $display("FAIL tmo_lat: got %0d want %0d", lat, DT + 1); end
      vec++; if (flc !== DT) begin errs++; $display("FAIL tmo_flush: got %0d cycles want %0d", flc, DT); end
      vec++; if ({err, fo, feat[35:24]} !== {1'b1, 12'hFFF, 12'hFFF})
         begin errs++; $display("FAIL tmo_rsp: got err=%b rsp=%h feat=%h want 1 fff fff", err, fo, feat[35:24]); end
      vec++; if ({side, pulse} !== 2'b11) begin errs++; $display("FAIL tmo_side: got side/pulse=%b want 11", {side, pulse}); end
   endtask

   task automatic test_invalid_hart;
      int lat, flc; logic err; logic [11:0] fo; bit side, rdy, pulse;
      issue(2'd3, 12'h0F0, 0, lat, err, fo, flc, side, rdy, pulse);
      vec++; if ({lat, flc, err, fo} !== {32'd1, 32'd0, 1'b1, 12'h000})
         begin errs++; $display("FAIL badhart: got lat=%0d flush=%0d err=%b feat=%h want 1 0 1 000", lat, flc, err, fo); end
   endtask

   task automatic test_other_harts;
      int lat, flc; logic err; logic [11:0] fo; bit side, rdy, pulse;
      issue(2'd1, 12'h0E1, 0, lat, err, fo, flc, side, rdy, pulse);
      mfeat[1] = 12'h0C1;
      vec++; if ({lat, err, fo} !== {32'd3, 1'b0, 12'h0C1}) begin errs++; $display("FAIL h1: got lat=%0d err=%b feat=%h want 3 0 0c1", lat, err, fo); end
      vec++; if (side !== 1'b1) begin errs++; $display("FAIL h1_side: other harts disturbed, got %b want 1", side); end
      vec++; if ({feat[11:0], flen[13:7], feat[35:24]} !== {12'h000, 7'd32, 12'hFFF})
         begin errs++; $display("FAIL h1_out: got h0=%h flen1=%0d h2=%h want 000 32 fff", feat[11:0], flen[13:7], feat[35:24]); end
      issue(2'd2, 12'h430, 1, lat, err, fo, flc, side, rdy, pulse);
      mfeat[2] = 12'h010;
      vec++; if ({lat, fo, flen[20:14], wb[8:6]} !== {32'd3, 12'h010, 7'd8, 3'd4})
         begin errs++; $display("FAIL legal_xfvec: got lat=%0d feat=%h flen=%0d wb=%0d want 3 010 8 4", lat, fo, flen[20:14], wb[8:6]); end
   endtask

   task automatic test_back_to_back;
      int lat, elat, flc, eflc; logic err, eerr; logic [11:0] fo, efo, rf; bit side, rdy, pulse, upd;
      for (int i = 0; i < 4; i++) begin
         rf = 12'($urandom);
         expect_req(2'(i % NH), rf, 0, elat, eerr, efo, eflc, upd);
         issue(2'(i % NH), rf, 0, lat, err, fo, flc, side, rdy, pulse);
         if (upd) mfeat[i % NH] = ref_legal(rf);
         vec++; if ({rdy, pulse, lat, err, fo} !== {2'b11, elat, eerr, efo})
            begin errs++; $display("FAIL b2b[%0d]: got rdy=%b pulse=%b lat=%0d err=%b feat=%h want 1 1 %0d %b %h",
               i, rdy, pulse, lat, err, fo, elat, eerr, efo); end
      end
   endtask

   task automatic test_random(input int n);
      logic [1:0] hart; logic [11:0] rf, fo, efo; logic err, eerr;
      int dly, lat, elat, flc, eflc; bit side, rdy, pulse, upd;
      for (int i = 0; i < n; i++) begin
         hart = 2'($urandom_range(0, 3));
         rf   = 12'($urandom);
         if (int'(hart) < NH && $urandom_range(0, 3) == 0) rf = mfeat[hart];
         dly  = int'($urandom_range(0, 11)) - 1;
         expect_req(hart, rf, dly, elat, eerr, efo, eflc, upd);
         issue(hart, rf, dly, lat, err, fo, flc, side, rdy, pulse);
         if (upd) mfeat[hart] = ref_legal(rf);
         vec++; if ({lat, flc} !== {elat, eflc}) begin errs++; $display("FAIL rand[%0d] timing: got lat=%0d flush=%0d want %0d %0d", i, lat, flc, elat, eflc); end
         vec++; if ({err, fo} !== {eerr, efo}) begin errs++; $display("FAIL rand[%0d] rsp: got err=%b feat=%h want %b %h", i, err, fo, eerr, efo); end
         vec++; if ({side, rdy, pulse} !== 3'b111) begin errs++; $display("FAIL rand[%0d] hs: got side/rdy/pulse=%b want 111", i, {side, rdy, pulse}); end
         for (int h = 0; h < NH; h++) begin
            vec++;
            if ({feat[h*12 +: 12], flen[h*7 +: 7], wb[h*3 +: 3]} !== {mfeat[h], 7'(ref_flen(mfeat[h])), 3'(ref_wb(mfeat[h]))})
               begin errs++; $display("FAIL rand[%0d] hart%0d: got feat=%h flen=%0d wb=%0d want %h %0d %0d", i, h,
                  feat[h*12 +: 12], flen[h*7 +: 7], wb[h*3 +: 3], mfeat[h], ref_flen(mfeat[h]), ref_wb(mfeat[h])); end
         end
      end
   endtask

   task automatic test_reset_in_drain;
      bit seen = 0;
      @(negedge clk);
      idle = '0;
      bus.req_valid_i = 1'b1;
      bus.req_hart_i  = 2'd1;
      bus.req_feat_i  = (ref_legal(12'h001) != mfeat[1]) ? 12'h001 : 12'h000;
      @(negedge clk);
      bus.req_valid_i = 1'b0;
      repeat (2) @(negedge clk);
      vec++; if (flush !== 3'b010) begin errs++; $display("FAIL rdrain_flush: got %b want 010", flush); end
      rst = 1'b1;
      #1;
      vec++; if ({bus.req_ready_o, flush} !== '0) begin errs++; $display("FAIL rdrain_hold: got rdy=%b flush=%b want 0 000", bus.req_ready_o, flush); end
      @(negedge clk);
      rst = 1'b0;
      for (int h = 0; h < NH; h++) mfeat[h] = ref_legal(RSTF);
      vec++; if ({flush, feat} !== {3'b000, {NH{12'hFFF}}}) begin errs++; $display("FAIL rdrain_out: got flush=%b feat=%h want 000 all fff", flush, feat); end
      for (int c = 0; c < 2 * DT; c++) begin
         @(negedge clk);
         if (bus.rsp_valid_o || flush != 0) seen = 1;
      end
      vec++; if (seen !== 1'b0) begin errs++; $display("FAIL rdrain_quiet: response or flush after abort, got %b want 0", seen); end
   endtask

   initial begin
      bus.req_valid_i = 1'b0;
      bus.req_hart_i  = '0;
      bus.req_feat_i  = '0;
      test_reset();
      test_d_without_f();
      test_no_change();
      test_timeout();
      test_invalid_hart();
      test_other_harts();
      test_back_to_back();
      test_random(60);
      test_reset_in_drain();
      test_random(20);
      $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
      $finish;
   end
endmodule
